// File: rtl/lrc_seq_pkg.sv
// Shared types and constants for the LRC row/frame sequencer.
// Optional flag statistics are enabled with LRC_SEQ_STATS_EN.
package lrc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROW_RST,
        FILL,
        DRAIN,
        ROW_END
    } state_e;

    localparam int PIPE_LAT = 22;

    localparam logic [1:0] FLAG_OK   = 2'b00;
    localparam logic [1:0] FLAG_MISM = 2'b01;
    localparam logic [1:0] FLAG_OCCL = 2'b10;

endpackage

// File: rtl/lrc_seq_stats.sv
// Per-frame occlusion / mismatch counters over the qualified output stream.
// Present only when LRC_SEQ_STATS_EN is defined.
module lrc_seq_stats #(
    parameter int CW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    input  logic [1:0]    flag,
    input  logic          frame_end,
    output logic [CW-1:0] stat_occl,
    output logic [CW-1:0] stat_mism,
    output logic          stat_vld
);
    import lrc_seq_pkg::*;

    logic [CW-1:0] occl_q, occl_d;
    logic [CW-1:0] mism_q, mism_d;
    logic          vld_q, vld_d;

    always_comb begin
        occl_d = occl_q;
        mism_d = mism_q;
        vld_d  = inc && frame_end;
        if (clr) begin
            occl_d = '0;
            mism_d = '0;
        end else if (inc) begin
            unique case (flag)
                FLAG_OCCL: occl_d = occl_q + 1'b1;
                FLAG_MISM: mism_d = mism_q + 1'b1;
                FLAG_OK:   ;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occl_q <= '0;
            mism_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            occl_q <= occl_d;
            mism_q <= mism_d;
            vld_q  <= vld_d;
        end
    end

    assign stat_occl = occl_q;
    assign stat_mism = mism_q;
    assign stat_vld  = vld_q;

endmodule

// File: rtl/lrc_row_sequencer.sv
// Row/frame sequencer for the left-right consistency checker.
// Define LRC_SEQ_STATS_EN to add the per-frame flag statistics outputs.
module lrc_row_sequencer #(
    parameter int DWIDTH   = 16,
    parameter int WWIDTH   = 10,
    parameter int HWIDTH   = 10,
    parameter int PIPE_LAT = lrc_seq_pkg::PIPE_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [WWIDTH-1:0] cfg_width,
    input  logic [HWIDTH-1:0] cfg_rows,
    input  logic [8:0]        cfg_range,
    input  logic [3:0]        cfg_lrc_param,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              out_ready,
    input  logic              lrc_valid,
    output logic              lrc_en,
    output logic              lrc_clken,
    output logic              lrc_row_rst_n,
    output logic              lrc_pad,
    output logic [8:0]        lrc_range,
    output logic [3:0]        lrc_param,
    output logic              out_valid,
    output logic              out_last,
    output logic              out_frame_end,
    output logic              busy,
    output logic [HWIDTH-1:0] row_idx
`ifdef LRC_SEQ_STATS_EN
    ,
    input  logic [1:0]               lrc_flag,
    output logic [WWIDTH+HWIDTH-1:0] stat_occl,
    output logic [WWIDTH+HWIDTH-1:0] stat_mism,
    output logic                     stat_vld
`endif
);
    import lrc_seq_pkg::*;

    if (DWIDTH < 9 || PIPE_LAT < 1) begin : g_param_chk
        $error("lrc_row_sequencer: DWIDTH or PIPE_LAT out of range");
    end

    state_e            state_q, state_d;
    logic [WWIDTH-1:0] width_q, width_d;
    logic [WWIDTH-1:0] in_cnt_q, in_cnt_d;
    logic [WWIDTH-1:0] out_cnt_q, out_cnt_d;
    logic [HWIDTH-1:0] rows_q, rows_d;
    logic [HWIDTH-1:0] row_q, row_d;
    logic [8:0]        range_q, range_d;
    logic [3:0]        param_q, param_d;
    logic              en_q, en_d;
    logic              pad_q, pad_d;
    logic              rrst_n_q, rrst_n_d;
    logic              busy_q, busy_d;

    logic start, active, emitting, rdy, advance, ovalid, olast;

    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        rows_d    = rows_q;
        range_d   = range_q;
        param_d   = param_q;
        row_d     = row_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        rdy       = 1'b0;
        advance   = 1'b0;
        start     = (state_q == IDLE) && frame_start &&
                    (cfg_width != '0) && (cfg_rows != '0);
        active    = (state_q == FILL) || (state_q == DRAIN);
        emitting  = active && lrc_valid && (out_cnt_q < width_q);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    width_d = cfg_width;
                    rows_d  = cfg_rows;
                    range_d = cfg_range;
                    param_d = cfg_lrc_param;
                    row_d   = '0;
                    state_d = ROW_RST;
                end
            end
            ROW_RST: begin
                in_cnt_d  = '0;
                out_cnt_d = '0;
                state_d   = FILL;
            end
            FILL: begin
                rdy     = out_ready || !emitting;
                advance = in_valid && rdy;
                if (advance) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == width_q - 1'b1)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                // No advance once the row is complete, so drain adds no extra beat.
                if (out_cnt_q >= width_q)
                    state_d = ROW_END;
                else
                    advance = !emitting || out_ready;
            end
            ROW_END: begin
                if (row_q == rows_q - 1'b1) begin
                    state_d = IDLE;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = ROW_RST;
                end
            end
            default: state_d = IDLE;
        endcase

        ovalid = emitting && advance;
        olast  = ovalid && (out_cnt_q == width_q - 1'b1);
        if (ovalid)
            out_cnt_d = out_cnt_q + 1'b1;

        en_d     = (state_d == FILL) || (state_d == DRAIN);
        pad_d    = (state_d == DRAIN);
        rrst_n_d = (state_d != ROW_RST);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            width_q   <= '0;
            rows_q    <= '0;
            range_q   <= '0;
            param_q   <= '0;
            row_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            en_q      <= 1'b0;
            pad_q     <= 1'b0;
            rrst_n_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            rows_q    <= rows_d;
            range_q   <= range_d;
            param_q   <= param_d;
            row_q     <= row_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            en_q      <= en_d;
            pad_q     <= pad_d;
            rrst_n_q  <= rrst_n_d;
            busy_q    <= busy_d;
        end
    end

    assign in_ready      = rdy;
    assign lrc_clken     = advance;
    assign lrc_en        = en_q;
    assign lrc_pad       = pad_q;
    assign lrc_row_rst_n = rrst_n_q;
    assign lrc_range     = range_q;
    assign lrc_param     = param_q;
    assign out_valid     = ovalid;
    assign out_last      = olast;
    assign out_frame_end = olast && (row_q == rows_q - 1'b1);
    assign busy          = busy_q;
    assign row_idx       = row_q;

`ifdef LRC_SEQ_STATS_EN
    lrc_seq_stats #(
        .CW(WWIDTH + HWIDTH)
    ) u_stats (
        .clk       (clk),
        .rst       (rst),
        .clr       (start),
        .inc       (ovalid),
        .flag      (lrc_flag),
        .frame_end (out_frame_end),
        .stat_occl (stat_occl),
        .stat_mism (stat_mism),
        .stat_vld  (stat_vld)
    );
`endif

endmodule

// File: tb/tb_lrc_row_sequencer.sv
// Directed bench for lrc_row_sequencer with a behavioural checker model.
// Stats outputs are exercised when LRC_SEQ_STATS_EN is defined.
module tb_lrc_row_sequencer;

    localparam int WW = 10;
    localparam int HW = 10;
    localparam int LAT = 22;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame_start = 1'b0;
    logic [WW-1:0] cfg_width = '0;
    logic [HW-1:0] cfg_rows = '0;
    logic [8:0]    cfg_range = '0;
    logic [3:0]    cfg_lrc_param = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          out_ready = 1'b1;
    logic          lrc_valid;
    logic          lrc_en, lrc_clken, lrc_row_rst_n, lrc_pad;
    logic [8:0]    lrc_range;
    logic [3:0]    lrc_param;
    logic          out_valid, out_last, out_frame_end, busy;
    logic [HW-1:0] row_idx;
`ifdef LRC_SEQ_STATS_EN
    logic [1:0]       lrc_flag;
    logic [WW+HW-1:0] stat_occl, stat_mism;
    logic             stat_vld;
`endif

    lrc_row_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .cfg_width     (cfg_width),
        .cfg_rows      (cfg_rows),
        .cfg_range     (cfg_range),
        .cfg_lrc_param (cfg_lrc_param),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_ready     (out_ready),
        .lrc_valid     (lrc_valid),
        .lrc_en        (lrc_en),
        .lrc_clken     (lrc_clken),
        .lrc_row_rst_n (lrc_row_rst_n),
        .lrc_pad       (lrc_pad),
        .lrc_range     (lrc_range),
        .lrc_param     (lrc_param),
        .out_valid     (out_valid),
        .out_last      (out_last),
        .out_frame_end (out_frame_end),
        .busy          (busy),
        .row_idx       (row_idx)
`ifdef LRC_SEQ_STATS_EN
        ,
        .lrc_flag      (lrc_flag),
        .stat_occl     (stat_occl),
        .stat_mism     (stat_mism),
        .stat_vld      (stat_vld)
`endif
    );

    always #5 clk = ~clk;

    // Checker model: output becomes valid after range+LAT enabled advances.
    int adv_cnt;
    int lat;
    always @(posedge clk or negedge rst) begin
        if (!rst)                adv_cnt <= 0;
        else if (!lrc_row_rst_n) adv_cnt <= 0;
        else if (lrc_clken)      adv_cnt <= adv_cnt + 1;
    end
    always_comb lat = int'(lrc_range) + LAT;
    always_comb lrc_valid = (adv_cnt >= lat);
`ifdef LRC_SEQ_STATS_EN
    always_comb begin
        lrc_flag = 2'b00;
        if (adv_cnt - lat < 3)      lrc_flag = 2'b10;
        else if (adv_cnt - lat < 5) lrc_flag = 2'b01;
    end
`endif

    typedef struct {
        int w;
        int rows;
        int rng;
        int on;
        int off;
        int tog;
        int chg;
        int exp_clk;
        int exp_first;
    } vec_t;

    vec_t vecs[9];
    int checks = 0;
    int errors = 0;
    int cur_w, cur_rows;
    int rc[8], rf[8], ro[8], sb[8], lc[8];
    int viol, fe, feb, vld;
    bit fe_prev;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic sample();
        int r;
        bit fill;
        r = int'(row_idx) & 7;
        fill = lrc_en && !lrc_pad;
        if (!lrc_row_rst_n) begin
            rc[r] = 0; rf[r] = 0; ro[r] = 0; sb[r] = 0; lc[r] = 0;
        end
        if (fill && in_ready != (out_ready || !(lrc_valid && ro[r] < cur_w)))
            viol++;
        if (!fill && in_ready) viol++;
        if (fill && !in_valid && lrc_clken) viol++;
        if (lrc_valid && ro[r] < cur_w && !out_ready && lrc_clken) viol++;
        if (out_last && !out_valid) sb[r]++;
        if (lrc_clken) rc[r]++;
        if (out_valid) begin
            if (rf[r] == 0) rf[r] = rc[r];
            if (adv_cnt - lat != ro[r]) sb[r]++;
            ro[r]++;
            if (out_last != (ro[r] == cur_w)) sb[r]++;
            if (out_last) lc[r]++;
        end
        if (out_frame_end) begin
            fe++;
            if (!out_last || r != cur_rows - 1) feb++;
        end
`ifdef LRC_SEQ_STATS_EN
        if (stat_vld) begin
            vld++;
            if (!fe_prev) feb++;
        end
`endif
        fe_prev = out_frame_end;
    endtask

    initial forever begin
        @(negedge clk);
        if (rst) sample();
    end

    task automatic run_frame(input int id, input vec_t v);
        bit done;
        int seen;
        cur_w = v.w;
        cur_rows = v.rows;
        foreach (rc[i]) begin
            rc[i] = 0; rf[i] = 0; ro[i] = 0; sb[i] = 0; lc[i] = 0;
        end
        viol = 0; fe = 0; feb = 0; vld = 0;
        @(posedge clk); #1;
        cfg_width = WW'(v.w);
        cfg_rows = HW'(v.rows);
        cfg_range = 9'(v.rng);
        cfg_lrc_param = 4'(id);
        frame_start = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        done = 0;
        for (int c = 0; c < 6000 && !done; c++) begin
            in_valid = (v.off == 0) ? 1'b1 : ((c % (v.on + v.off)) < v.on);
            out_ready = (v.tog != 0) ? (c % 2 == 0) : 1'b1;
            if (v.chg != 0 && c == 10) begin
                cfg_range = 9'd60;
                cfg_width = WW'(3);
                cfg_rows = HW'(1);
                frame_start = 1'b1;
            end
            if (v.chg != 0 && c == 11) frame_start = 1'b0;
            if (v.chg != 0 && c == 20)
                check($sformatf("v%0d range_hold", id), int'(lrc_range), v.rng);
            @(posedge clk); #1;
            if (!busy) done = 1;
        end
        check($sformatf("v%0d timeout", id), int'(done), 1);
        seen = 0;
        for (int r = 0; r < 8; r++) if (rc[r] > 0) seen++;
        check($sformatf("v%0d rows", id), seen, v.rows);
        for (int r = 0; r < v.rows && r < 8; r++) begin
            check($sformatf("v%0d r%0d clken", id, r), rc[r], v.exp_clk);
            check($sformatf("v%0d r%0d first", id, r), rf[r], v.exp_first);
            check($sformatf("v%0d r%0d outs", id, r), ro[r], v.w);
            check($sformatf("v%0d r%0d seq", id, r), sb[r], 0);
            check($sformatf("v%0d r%0d last", id, r), lc[r], 1);
        end
        check($sformatf("v%0d frame_end", id), fe, 1);
        check($sformatf("v%0d fe_pos", id), feb, 0);
        check($sformatf("v%0d handshake", id), viol, 0);
        check($sformatf("v%0d lrc_range", id), int'(lrc_range), v.rng);
        check($sformatf("v%0d lrc_param", id), int'(lrc_param), id);
        check($sformatf("v%0d idle_en", id), int'(lrc_en), 0);
    endtask

    task automatic check_reset_outs(input string nm);
        check({nm, " ctl"}, int'({in_ready, lrc_en, lrc_clken, lrc_row_rst_n,
              lrc_pad, out_valid, out_last, out_frame_end, busy}), 32);
        check({nm, " range"}, int'(lrc_range), 0);
        check({nm, " param"}, int'(lrc_param), 0);
        check({nm, " row"}, int'(row_idx), 0);
    endtask

    initial begin
        vecs[0] = '{8, 2, 4, 1, 0, 0, 0, 34, 27};
        vecs[1] = '{16, 2, 4, 1, 0, 1, 0, 42, 27};
        vecs[2] = '{8, 1, 10, 2, 3, 0, 0, 40, 33};
        vecs[3] = '{1, 3, 0, 1, 0, 0, 0, 23, 23};
        vecs[4] = '{12, 1, 7, 2, 3, 1, 0, 41, 30};
        vecs[5] = '{8, 2, 4, 1, 0, 0, 1, 34, 27};
        vecs[6] = '{5, 1, 511, 1, 0, 0, 0, 538, 534};
        vecs[7] = '{40, 1, 2, 2, 3, 1, 0, 64, 25};
        vecs[8] = '{40, 2, 2, 1, 0, 1, 0, 64, 25};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("in_reset");
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outs("after_reset");

        // Zero width or zero rows must not start a frame.
        cfg_width = '0; cfg_rows = HW'(2); frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(posedge clk); #1;
        check("zero_width busy", int'(busy), 0);
        cfg_width = WW'(8); cfg_rows = '0; frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(posedge clk); #1;
        check("zero_rows busy", int'(busy), 0);

        for (int i = 0; i < 9; i++) run_frame(i, vecs[i]);

        // Async reset in the middle of row 1 drain.
        cur_w = 8; cur_rows = 2;
        @(posedge clk); #1;
        cfg_width = WW'(8); cfg_rows = HW'(2); cfg_range = 9'd4;
        in_valid = 1'b1; out_ready = 1'b1; frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        for (int c = 0; c < 500 && !(row_idx == 1 && lrc_pad); c++) begin
            @(posedge clk); #1;
        end
        check("rst_reach_drain", int'(row_idx == 1 && lrc_pad), 1);
        #2 rst = 1'b0;
        #1 check_reset_outs("async_rst");
        #3 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_restart busy", int'(busy), 0);
        run_frame(0, vecs[0]);

`ifdef LRC_SEQ_STATS_EN
        run_frame(9, '{8, 1, 4, 1, 0, 0, 0, 34, 27});
        check("stat_occl", int'(stat_occl), 3);
        check("stat_mism", int'(stat_mism), 2);
        check("stat_vld pulses", vld, 1);
        repeat (3) @(posedge clk);
        #1;
        check("stat_occl held", int'(stat_occl), 3);
        check("stat_vld single", vld, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
